// File: rtl/trv_port_arbiter.sv
// Round-robin merge of per-thread init-request streams into one traversal core,
// with TID-based routing of traversal responses and a per-thread in-flight quota.
module trv_port_arbiter #(
  parameter int NUM_THREADS    = 4,
  parameter int TID_WIDTH      = 2,
  parameter int INIT_REQ_WIDTH = 64,
  parameter int TRV_RESP_WIDTH = 48,
  parameter int MAX_INFLIGHT   = 8
) (
  input  logic                                  clk,
  input  logic                                  arst_n,
  input  logic [NUM_THREADS-1:0]                init_req_in_empty_n,
  output logic [NUM_THREADS-1:0]                init_req_in_read,
  input  logic [NUM_THREADS*INIT_REQ_WIDTH-1:0] init_req_in_dout,
  input  logic                                  init_req_out_full_n,
  output logic                                  init_req_out_write,
  output logic [INIT_REQ_WIDTH-1:0]             init_req_out_din,
  input  logic                                  trv_resp_in_empty_n,
  output logic                                  trv_resp_in_read,
  input  logic [TRV_RESP_WIDTH-1:0]             trv_resp_in_dout,
  input  logic [NUM_THREADS-1:0]                trv_resp_out_full_n,
  output logic [NUM_THREADS-1:0]                trv_resp_out_write,
  output logic [TRV_RESP_WIDTH-1:0]             trv_resp_out_din,
  output logic                                  err
);

  localparam int PTR_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);
  localparam logic [NUM_THREADS-1:0] ONE_HOT0 = NUM_THREADS'(1);

  logic [PTR_W-1:0]       rr_ptr;
  logic [CNT_W-1:0]       inflight [NUM_THREADS];
  logic [NUM_THREADS-1:0] eligible;
  logic                   gnt_vld;
  logic [PTR_W-1:0]       gnt_idx;
  logic                   gnt_fire;
  logic [TID_WIDTH-1:0]   rsp_tid;
  logic [NUM_THREADS-1:0] tgt_oh;
  logic                   tid_ok;
  logic                   tgt_ready;
  logic                   rsp_deliver;
  logic                   rsp_drop;

  // Eligibility uses the registered count, so a same-cycle response never unblocks a full thread
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      eligible[i] = init_req_in_empty_n[i] && (inflight[i] < CNT_MAX);
    end
  end

  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_THREADS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_THREADS) idx = idx - NUM_THREADS;
      if (!gnt_vld && |(eligible & (ONE_HOT0 << idx))) begin
        gnt_vld = 1'b1;
        gnt_idx = PTR_W'(idx);
      end
    end
  end

  assign gnt_fire           = arst_n && init_req_out_full_n && gnt_vld;
  assign init_req_in_read   = gnt_fire ? (ONE_HOT0 << gnt_idx) : '0;
  assign init_req_out_write = gnt_fire;
  assign init_req_out_din   = init_req_in_dout[gnt_idx*INIT_REQ_WIDTH +: INIT_REQ_WIDTH];

  // Out-of-range TIDs shift the one-hot to zero, so they never select a target
  assign rsp_tid            = trv_resp_in_dout[TID_WIDTH-1:0];
  assign tid_ok             = int'(rsp_tid) < NUM_THREADS;
  assign tgt_oh             = ONE_HOT0 << rsp_tid;
  assign tgt_ready          = |(trv_resp_out_full_n & tgt_oh);
  assign rsp_deliver        = arst_n && trv_resp_in_empty_n && tid_ok && tgt_ready;
  assign rsp_drop           = arst_n && trv_resp_in_empty_n && !tid_ok;
  assign trv_resp_in_read   = rsp_deliver || rsp_drop;
  assign trv_resp_out_write = rsp_deliver ? tgt_oh : '0;
  assign trv_resp_out_din   = trv_resp_in_dout;

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      rr_ptr <= '0;
      err    <= 1'b0;
      for (int i = 0; i < NUM_THREADS; i++) begin
        inflight[i] <= '0;
      end
    end else begin
      if (gnt_fire) begin
        rr_ptr <= (gnt_idx == PTR_W'(NUM_THREADS - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (rsp_drop) err <= 1'b1;
      for (int i = 0; i < NUM_THREADS; i++) begin
        if (trv_resp_out_write[i] && (inflight[i] == '0)) err <= 1'b1;
        case ({init_req_in_read[i], trv_resp_out_write[i]})
          2'b10:   inflight[i] <= inflight[i] + 1'b1;
          2'b01:   if (inflight[i] != '0) inflight[i] <= inflight[i] - 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trv_port_arbiter.sv
// Directed bench for trv_port_arbiter: a vector table for the 4-thread instance
// plus hand-written sequences for quota, reset, error and 3-thread wrap cases.
module tb_trv_port_arbiter;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  // 4-thread instance
  logic [3:0]   a_req_vld, a_req_rd, a_rsp_full_n, a_rsp_wr;
  logic [255:0] a_req_dout;
  logic         a_out_full_n, a_out_wr, a_rsp_vld, a_rsp_rd, a_err;
  logic [63:0]  a_out_din;
  logic [47:0]  a_rsp_dout, a_rsp_din;

  // 3-thread instance
  logic [2:0]   b_req_vld, b_req_rd, b_rsp_full_n, b_rsp_wr;
  logic [191:0] b_req_dout;
  logic         b_out_full_n, b_out_wr, b_rsp_vld, b_rsp_rd, b_err;
  logic [63:0]  b_out_din;
  logic [47:0]  b_rsp_dout, b_rsp_din;

  trv_port_arbiter #(.NUM_THREADS(4), .TID_WIDTH(2), .INIT_REQ_WIDTH(64),
                     .TRV_RESP_WIDTH(48), .MAX_INFLIGHT(8)) dut4 (
    .clk(clk), .arst_n(arst_n),
    .init_req_in_empty_n(a_req_vld), .init_req_in_read(a_req_rd),
    .init_req_in_dout(a_req_dout), .init_req_out_full_n(a_out_full_n),
    .init_req_out_write(a_out_wr), .init_req_out_din(a_out_din),
    .trv_resp_in_empty_n(a_rsp_vld), .trv_resp_in_read(a_rsp_rd),
    .trv_resp_in_dout(a_rsp_dout), .trv_resp_out_full_n(a_rsp_full_n),
    .trv_resp_out_write(a_rsp_wr), .trv_resp_out_din(a_rsp_din), .err(a_err));

  trv_port_arbiter #(.NUM_THREADS(3), .TID_WIDTH(2), .INIT_REQ_WIDTH(64),
                     .TRV_RESP_WIDTH(48), .MAX_INFLIGHT(8)) dut3 (
    .clk(clk), .arst_n(arst_n),
    .init_req_in_empty_n(b_req_vld), .init_req_in_read(b_req_rd),
    .init_req_in_dout(b_req_dout), .init_req_out_full_n(b_out_full_n),
    .init_req_out_write(b_out_wr), .init_req_out_din(b_out_din),
    .trv_resp_in_empty_n(b_rsp_vld), .trv_resp_in_read(b_rsp_rd),
    .trv_resp_in_dout(b_rsp_dout), .trv_resp_out_full_n(b_rsp_full_n),
    .trv_resp_out_write(b_rsp_wr), .trv_resp_out_din(b_rsp_din), .err(b_err));

  typedef struct {
    logic [3:0]  req;
    logic        full_n;
    logic        rvld;
    logic [47:0] rdata;
    logic [3:0]  rfull;
    logic [3:0]  e_rd;
    logic        e_wr;
    logic        e_rrd;
    logic [3:0]  e_rwr;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [47:0] R2 = 48'h5A5A_1234_0002;
  localparam logic [47:0] R0 = 48'hBEEF_CAFE_0100;
  localparam logic [47:0] R3 = 48'h0F0F_F0F0_0003;
  localparam logic [47:0] R1 = 48'h7777_0000_0005;

  function automatic vec_t v(logic [3:0] req, logic full_n, logic rvld, logic [47:0] rdata,
                             logic [3:0] rfull, logic [3:0] e_rd, logic e_wr,
                             logic e_rrd, logic [3:0] e_rwr);
    vec_t r;
    r.req = req; r.full_n = full_n; r.rvld = rvld; r.rdata = rdata; r.rfull = rfull;
    r.e_rd = e_rd; r.e_wr = e_wr; r.e_rrd = e_rrd; r.e_rwr = e_rwr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_req_vld = '0; a_out_full_n = 1'b1; a_rsp_vld = 1'b0;
    a_rsp_dout = '0; a_rsp_full_n = 4'hF;
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    a_idle();
    tick();
    arst_n = 1'b1;
  endtask

  // Counts grants to one thread over a fixed window with only that thread requesting
  task automatic count_grants(input int thr, input int cycles, output int cnt);
    cnt = 0;
    a_req_vld = 4'b0001 << thr;
    for (int c = 0; c < cycles; c++) begin
      #1;
      if (a_req_rd[thr]) cnt++;
      tick();
    end
    a_req_vld = '0;
  endtask

  initial begin
    int cnt;
    int g;
    for (int i = 0; i < 4; i++) a_req_dout[i*64 +: 64] = {32'hC0DE_0000 | i, 32'h1234_5670 + i};
    for (int i = 0; i < 3; i++) b_req_dout[i*64 +: 64] = {32'hB0B0_0000 | i, 32'h0BAD_F000 + i};
    b_req_vld = '0; b_out_full_n = 1'b1; b_rsp_vld = 1'b0; b_rsp_dout = '0; b_rsp_full_n = 3'b111;

    // Round robin, backpressure, sparse requests, response routing with stall
    tbl.push_back(v(4'b1111, 1, 0, 48'h0, 4'hF, 4'b0001, 1, 0, 4'b0000));
    tbl.push_back(v(4'b1111, 1, 0, 48'h0, 4'hF, 4'b0010, 1, 0, 4'b0000));
    tbl.push_back(v(4'b1111, 1, 0, 48'h0, 4'hF, 4'b0100, 1, 0, 4'b0000));
    tbl.push_back(v(4'b1111, 1, 0, 48'h0, 4'hF, 4'b1000, 1, 0, 4'b0000));
    tbl.push_back(v(4'b1111, 1, 0, 48'h0, 4'hF, 4'b0001, 1, 0, 4'b0000));
    for (int i = 0; i < 5; i++)
      tbl.push_back(v(4'b1111, 0, 0, 48'h0, 4'hF, 4'b0000, 0, 0, 4'b0000));
    tbl.push_back(v(4'b1111, 1, 0, 48'h0, 4'hF, 4'b0010, 1, 0, 4'b0000));
    tbl.push_back(v(4'b1001, 1, 0, 48'h0, 4'hF, 4'b1000, 1, 0, 4'b0000));
    tbl.push_back(v(4'b0110, 1, 0, 48'h0, 4'hF, 4'b0010, 1, 0, 4'b0000));
    tbl.push_back(v(4'b0000, 1, 0, 48'h0, 4'hF, 4'b0000, 0, 0, 4'b0000));
    tbl.push_back(v(4'b0000, 1, 1, R2,    4'hF, 4'b0000, 0, 1, 4'b0100));
    for (int i = 0; i < 3; i++)
      tbl.push_back(v(4'b0000, 1, 1, R0, 4'b1110, 4'b0000, 0, 0, 4'b0000));
    tbl.push_back(v(4'b0000, 1, 1, R0,    4'hF, 4'b0000, 0, 1, 4'b0001));
    tbl.push_back(v(4'b0000, 1, 1, R3,    4'hF, 4'b0000, 0, 1, 4'b1000));
    tbl.push_back(v(4'b0100, 1, 0, 48'h0, 4'hF, 4'b0100, 1, 0, 4'b0000));
    tbl.push_back(v(4'b0001, 1, 1, R0,    4'hF, 4'b0001, 1, 1, 4'b0001));

    arst_n = 1'b0;
    a_idle();
    tick();
    #1;
    chk("reset_req_rd", a_req_rd, 0);
    chk("reset_out_wr", a_out_wr, 0);
    tick();
    arst_n = 1'b1;
    chk("reset_err", a_err, 0);

    for (int n = 0; n < tbl.size(); n++) begin
      a_req_vld = tbl[n].req; a_out_full_n = tbl[n].full_n;
      a_rsp_vld = tbl[n].rvld; a_rsp_dout = tbl[n].rdata; a_rsp_full_n = tbl[n].rfull;
      #1;
      chk($sformatf("tbl%0d_req_rd", n), a_req_rd, tbl[n].e_rd);
      chk($sformatf("tbl%0d_out_wr", n), a_out_wr, tbl[n].e_wr);
      chk($sformatf("tbl%0d_rsp_rd", n), a_rsp_rd, tbl[n].e_rrd);
      chk($sformatf("tbl%0d_rsp_wr", n), a_rsp_wr, tbl[n].e_rwr);
      chk($sformatf("tbl%0d_err", n), a_err, 0);
      if (tbl[n].e_wr) begin
        g = 0;
        for (int j = 0; j < 4; j++) if (tbl[n].e_rd[j]) g = j;
        chk($sformatf("tbl%0d_out_din", n), a_out_din, a_req_dout[g*64 +: 64]);
      end
      if (tbl[n].rvld) chk($sformatf("tbl%0d_rsp_din", n), a_rsp_din, tbl[n].rdata);
      tick();
    end
    a_idle();

    // Quota: exactly MAX_INFLIGHT grants, a same-cycle response does not unblock
    do_reset();
    count_grants(1, 12, cnt);
    chk("quota_grants", cnt, 8);
    a_req_vld = 4'b0010; a_rsp_vld = 1'b1; a_rsp_dout = R1;
    #1;
    chk("quota_same_cycle_rd", a_req_rd, 4'b0000);
    chk("quota_rsp_wr", a_rsp_wr, 4'b0010);
    tick();
    a_rsp_vld = 1'b0;
    #1;
    chk("quota_resume_rd", a_req_rd, 4'b0010);
    tick();
    a_idle();

    // Simultaneous grant and response at inflight 5 leaves the count at 5
    do_reset();
    count_grants(0, 5, cnt);
    chk("simul_pre_grants", cnt, 5);
    a_req_vld = 4'b0001; a_rsp_vld = 1'b1; a_rsp_dout = R0;
    #1;
    chk("simul_req_rd", a_req_rd, 4'b0001);
    chk("simul_rsp_wr", a_rsp_wr, 4'b0001);
    tick();
    a_rsp_vld = 1'b0;
    count_grants(0, 8, cnt);
    chk("simul_remaining_grants", cnt, 3);
    chk("simul_err", a_err, 0);

    // Response to an idle thread: delivered, err set, counter does not underflow
    do_reset();
    a_rsp_vld = 1'b1; a_rsp_dout = R2;
    #1;
    chk("idle_rsp_rd", a_rsp_rd, 1);
    chk("idle_rsp_wr", a_rsp_wr, 4'b0100);
    tick();
    a_rsp_vld = 1'b0;
    #1;
    chk("idle_err_set", a_err, 1);
    count_grants(2, 10, cnt);
    chk("idle_no_underflow", cnt, 8);
    chk("idle_err_sticky", a_err, 1);

    // Reset after 4 grants clears counts, err and pointer
    do_reset();
    count_grants(1, 4, cnt);
    chk("rst_pre_grants", cnt, 4);
    a_rsp_vld = 1'b1; a_rsp_dout = R3;
    tick();
    a_rsp_vld = 1'b0;
    #1;
    chk("rst_err_before", a_err, 1);
    arst_n = 1'b0;
    a_req_vld = 4'b1111; a_out_full_n = 1'b1;
    a_rsp_vld = 1'b1; a_rsp_dout = R1; a_rsp_full_n = 4'hF;
    #1;
    chk("rst_hold_req_rd", a_req_rd, 0);
    chk("rst_hold_out_wr", a_out_wr, 0);
    chk("rst_hold_rsp_rd", a_rsp_rd, 0);
    chk("rst_hold_rsp_wr", a_rsp_wr, 0);
    tick();
    arst_n = 1'b1;
    a_rsp_vld = 1'b0;
    #1;
    chk("rst_err_cleared", a_err, 0);
    chk("rst_ptr_zero", a_req_rd, 4'b0001);
    tick();
    a_idle();
    count_grants(1, 10, cnt);
    chk("rst_counts_cleared", cnt, 8);

    // 3-thread instance: wrap 2 -> 0, invalid TID dropped with err
    do_reset();
    b_req_vld = 3'b111;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("n3_grant%0d", i), b_req_rd, 3'b001 << (i % 3));
      chk($sformatf("n3_din%0d", i), b_out_din, b_req_dout[(i % 3)*64 +: 64]);
      tick();
    end
    b_req_vld = '0;
    b_rsp_vld = 1'b1; b_rsp_dout = R3;
    #1;
    chk("n3_badtid_rd", b_rsp_rd, 1);
    chk("n3_badtid_wr", b_rsp_wr, 3'b000);
    tick();
    b_rsp_vld = 1'b0;
    #1;
    chk("n3_badtid_err", b_err, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
